// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the slave select controller.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] MUX_SEL_NONE = 3'b000;
    localparam logic [2:0] MUX_SEL_S1   = 3'b001;
    localparam logic [2:0] MUX_SEL_S2   = 3'b010;
    localparam logic [2:0] MUX_SEL_S3   = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2,
        ST_TMO1,
        ST_TMO2
    } ahb_state_e;

    // NONSEQ/SEQ carry a data phase; IDLE/BUSY do not.
    function automatic logic trans_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY: act = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            default: act = 1'b0;
        endcase
        return act;
    endfunction

    // Region tag to response-mux code; slave 1 wins if regions overlap.
    function automatic logic [2:0] region_decode(input logic [3:0] tag,
                                                 input logic [3:0] r1,
                                                 input logic [3:0] r2,
                                                 input logic [3:0] r3);
        logic [2:0] code;
        if (tag == r1)      code = MUX_SEL_S1;
        else if (tag == r2) code = MUX_SEL_S2;
        else if (tag == r3) code = MUX_SEL_S3;
        else                code = MUX_SEL_NONE;
        return code;
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response sequencing (ERR1/ERR2 and the
// identically shaped TMO1/TMO2 watchdog response).
module ahb_default_slave
    import ahb_pkg::*;
(
    input  ahb_state_e state_i,
    input  logic       unmapped_act_i,
    output logic       busy_o,
    output logic       hready_o,
    output logic [1:0] hresp_o,
    output ahb_state_e state_nxt_o
);

    // First cycle stalls with ERROR, second completes with ERROR and accepts.
    always_comb begin
        busy_o      = 1'b0;
        hready_o    = 1'b1;
        hresp_o     = HRESP_OKAY;
        state_nxt_o = ST_IDLE;
        case (state_i)
            ST_ERR1: begin
                busy_o      = 1'b1;
                hready_o    = 1'b0;
                hresp_o     = HRESP_ERROR;
                state_nxt_o = ST_ERR2;
            end
            ST_TMO1: begin
                busy_o      = 1'b1;
                hready_o    = 1'b0;
                hresp_o     = HRESP_ERROR;
                state_nxt_o = ST_TMO2;
            end
            ST_ERR2, ST_TMO2: begin
                busy_o      = 1'b1;
                hready_o    = 1'b1;
                hresp_o     = HRESP_ERROR;
                state_nxt_o = unmapped_act_i ? ST_ERR1 : ST_IDLE;
            end
            default: begin
                busy_o      = 1'b0;
                state_nxt_o = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_slave_sel_ctrl.sv
// AHB-Lite address decoder, data-phase owner tracking, response merge,
// default slave and slave stall watchdog for a 3-slave response mux.
module ahb_slave_sel_ctrl
    import ahb_pkg::*;
#(
    parameter logic [3:0]  REGION_1  = 4'h0,
    parameter logic [3:0]  REGION_2  = 4'h1,
    parameter logic [3:0]  REGION_3  = 4'h2,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [31:0]          haddr,
    input  logic [1:0]           htrans,
    input  logic                 hreadyout_mux,
    input  logic [1:0]           hresp_mux,
    input  logic                 err_clr,
    output logic                 hsel_1,
    output logic                 hsel_2,
    output logic                 hsel_3,
    output logic [2:0]           mux_sel,
    output logic                 hready,
    output logic [1:0]           hresp,
    output logic                 timeout_flag,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    ahb_state_e           state_q, state_d;
    logic [2:0]           dsel_q, dsel_d;
    logic                 dact_q, dact_d;
    logic [7:0]           stall_q, stall_d;
    logic                 flag_q, flag_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [2:0]  dec_code;
    logic        unmapped_act;
    logic        hready_int;
    logic [1:0]  hresp_int;
    logic        stall_inc;
    logic        wdog_fire;
    logic        ds_busy;
    logic        ds_hready;
    logic [1:0]  ds_hresp;
    ahb_state_e  ds_nxt;
    logic        unused_haddr;

    assign unused_haddr = ^haddr[27:0];

    assign hsel_1 = (haddr[31:28] == REGION_1);
    assign hsel_2 = (haddr[31:28] == REGION_2);
    assign hsel_3 = (haddr[31:28] == REGION_3);

    assign dec_code     = region_decode(haddr[31:28], REGION_1, REGION_2, REGION_3);
    assign unmapped_act = (dec_code == MUX_SEL_NONE) && trans_active(htrans);

    // Stall counting only while a mapped, active data phase is being held off.
    assign stall_inc = (state_q == ST_IDLE) && (dsel_q != MUX_SEL_NONE) && dact_q && !hreadyout_mux;
    assign wdog_fire = (TIMEOUT != 0) && stall_inc && (stall_q == TMO_LAST);

    ahb_default_slave u_default_slave (
        .state_i        (state_q),
        .unmapped_act_i (unmapped_act),
        .busy_o         (ds_busy),
        .hready_o       (ds_hready),
        .hresp_o        (ds_hresp),
        .state_nxt_o    (ds_nxt)
    );

    // FSM state register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: IDLE handled here, error sequences by the default slave.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (hready_int && unmapped_act) state_d = ST_ERR1;
            else if (wdog_fire)             state_d = ST_TMO1;
        end else begin
            state_d = ds_nxt;
        end
    end

    // FSM outputs: error response, slave pass-through, or zero-wait OKAY.
    always_comb begin
        hready_int = 1'b1;
        hresp_int  = HRESP_OKAY;
        mux_sel    = dsel_q;
        if (ds_busy) begin
            hready_int = ds_hready;
            hresp_int  = ds_hresp;
        end else if (dsel_q != MUX_SEL_NONE) begin
            hready_int = hreadyout_mux;
            hresp_int  = hresp_mux;
        end
        if (state_q == ST_TMO1 || state_q == ST_TMO2) mux_sel = MUX_SEL_NONE;
    end

    assign hready = hready_int;
    assign hresp  = hresp_int;

    // Data-phase bookkeeping, watchdog and error statistics next-state.
    always_comb begin
        dsel_d    = dsel_q;
        dact_d    = dact_q;
        stall_d   = '0;
        flag_d    = flag_q;
        err_cnt_d = err_cnt_q;
        if (hready_int) begin
            dsel_d = dec_code;
            dact_d = trans_active(htrans);
        end
        if (stall_inc && !wdog_fire) stall_d = stall_q + 8'd1;
        if (state_q == ST_TMO1) flag_d = 1'b1;
        else if (err_clr)       flag_d = 1'b0;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if ((state_d == ST_ERR1 || state_d == ST_TMO1) && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Data-phase, watchdog and statistics registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel_q    <= MUX_SEL_NONE;
            dact_q    <= 1'b0;
            stall_q   <= '0;
            flag_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            dsel_q    <= dsel_d;
            dact_q    <= dact_d;
            stall_q   <= stall_d;
            flag_q    <= flag_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign timeout_flag = flag_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ahb_slave_sel_ctrl.sv
// Self-checking bench for ahb_slave_sel_ctrl: transaction-level model plus
// directed scenarios with literal expectations.
module tb_ahb_slave_sel_ctrl;

    localparam int TMO  = 16;
    localparam int CMAX = 255;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hreadyout_mux;
    logic [1:0]  hresp_mux;
    logic        err_clr;
    logic        hsel_1, hsel_2, hsel_3;
    logic [2:0]  mux_sel;
    logic        hready;
    logic [1:0]  hresp;
    logic        timeout_flag;
    logic [7:0]  err_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    ahb_slave_sel_ctrl #(
        .REGION_1  (4'h0),
        .REGION_2  (4'h1),
        .REGION_3  (4'h2),
        .TIMEOUT   (TMO),
        .ERR_CNT_W (8)
    ) dut (
        .hclk          (hclk),
        .hresetn       (hresetn),
        .haddr         (haddr),
        .htrans        (htrans),
        .hreadyout_mux (hreadyout_mux),
        .hresp_mux     (hresp_mux),
        .err_clr       (err_clr),
        .hsel_1        (hsel_1),
        .hsel_2        (hsel_2),
        .hsel_3        (hsel_3),
        .mux_sel       (mux_sel),
        .hready        (hready),
        .hresp         (hresp),
        .timeout_flag  (timeout_flag),
        .err_cnt       (err_cnt)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: err_left counts remaining ERROR cycles (2 = stalled, 1 = completing).
    int m_err = 0, m_owner = 0, m_stall = 0, m_cnt = 0;
    bit m_act = 0, m_tmo = 0, m_flag = 0;

    function automatic int region_of(input logic [31:0] a);
        case (a[31:28])
            4'h0: return 1;
            4'h1: return 2;
            4'h2: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_ready();
        if (m_err == 2) return 1'b0;
        if (m_err == 1) return 1'b1;
        if (m_owner != 0) return hreadyout_mux;
        return 1'b1;
    endfunction

    function automatic logic [1:0] exp_resp();
        if (m_err != 0) return 2'b01;
        if (m_owner != 0) return hresp_mux;
        return 2'b00;
    endfunction

    always @(posedge hclk or negedge hresetn) begin : model
        int e, own, st, cnt;
        bit act, tmo, flg, inc, fset;
        if (!hresetn) begin
            m_err <= 0; m_owner <= 0; m_stall <= 0; m_cnt <= 0;
            m_act <= 0; m_tmo <= 0; m_flag <= 0;
        end else begin
            e = m_err; own = m_owner; st = m_stall; cnt = m_cnt;
            act = m_act; tmo = m_tmo; flg = m_flag; inc = 0;
            fset = (m_err == 2) && m_tmo;
            if (e == 2) begin
                e = 1;
            end else if (exp_ready()) begin
                own = region_of(haddr);
                act = htrans[1];
                st  = 0;
                tmo = 0;
                if (own == 0 && act) begin e = 2; inc = 1; end
                else e = 0;
            end else begin
                st = act ? st + 1 : 0;
                if (TMO > 0 && st == TMO) begin e = 2; tmo = 1; inc = 1; st = 0; end
            end
            if (err_clr) cnt = 0;
            else if (inc && cnt < CMAX) cnt = cnt + 1;
            if (err_clr) flg = 0;
            if (fset) flg = 1;
            m_err <= e; m_owner <= own; m_stall <= st; m_cnt <= cnt;
            m_act <= act; m_tmo <= tmo; m_flag <= flg;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge hclk) begin
        if (cmp_en) begin
            chk("hsel_1", 32'(hsel_1), 32'(haddr[31:28] == 4'h0));
            chk("hsel_2", 32'(hsel_2), 32'(haddr[31:28] == 4'h1));
            chk("hsel_3", 32'(hsel_3), 32'(haddr[31:28] == 4'h2));
            chk("hready", 32'(hready), 32'(exp_ready()));
            chk("hresp", 32'(hresp), 32'(exp_resp()));
            chk("mux_sel", 32'(mux_sel), (m_err != 0 && m_tmo) ? 32'd0 : 32'(m_owner));
            chk("timeout_flag", 32'(timeout_flag), 32'(m_flag));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [1:0] t);
        haddr  = a;
        htrans = t;
    endtask

    initial begin
        int low;
        hresetn = 1'b0;
        bus(32'hF000_0000, 2'b00);
        hreadyout_mux = 1'b1;
        hresp_mux     = 2'b00;
        err_clr       = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) tick();
        hresetn = 1'b1;

        // Idle bus after reset
        @(negedge hclk);
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_mux", 32'(mux_sel), 32'd0);
        chk("rst_hsel", {29'd0, hsel_3, hsel_2, hsel_1}, 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);

        // Slave 2 transfer, one wait state then completion
        tick();
        bus(32'h1000_0040, 2'b10);
        @(negedge hclk);
        chk("s2_hsel2", 32'(hsel_2), 32'd1);
        tick();
        bus(32'hF000_0000, 2'b00);
        hreadyout_mux = 1'b0;
        @(negedge hclk);
        chk("s2_mux", 32'(mux_sel), 32'd2);
        chk("s2_wait", 32'(hready), 32'd0);
        tick();
        hreadyout_mux = 1'b1;
        @(negedge hclk);
        chk("s2_done", 32'(hready), 32'd1);
        chk("s2_mux_held", 32'(mux_sel), 32'd2);
        tick();

        // Slave 3 pass-through of a slave ERROR response
        bus(32'h2000_0100, 2'b10);
        tick();
        bus(32'hF000_0000, 2'b00);
        hresp_mux = 2'b01;
        @(negedge hclk);
        chk("s3_mux", 32'(mux_sel), 32'd3);
        chk("s3_resp", 32'(hresp), 32'd1);
        tick();
        hresp_mux = 2'b00;
        tick();

        // Unmapped NONSEQ: two-cycle ERROR
        bus(32'h3000_0000, 2'b10);
        tick();
        bus(32'hF000_0000, 2'b00);
        @(negedge hclk);
        chk("err1_hready", 32'(hready), 32'd0);
        chk("err1_hresp", 32'(hresp), 32'd1);
        tick();
        @(negedge hclk);
        chk("err2_hready", 32'(hready), 32'd1);
        chk("err2_hresp", 32'(hresp), 32'd1);
        chk("err_cnt_1", 32'(err_cnt), 32'd1);
        tick();

        // Back-to-back unmapped NONSEQ from a cleared counter
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        bus(32'h3000_0000, 2'b10);
        tick();
        tick();
        @(negedge hclk);
        chk("b2b_err2", {30'd0, hready, hresp[0]}, 32'd3);
        tick();
        bus(32'hF000_0000, 2'b00);
        @(negedge hclk);
        chk("b2b_err1", {30'd0, hready, hresp[0]}, 32'd1);
        chk("b2b_cnt", 32'(err_cnt), 32'd2);
        tick();
        tick();

        // Slave 1 stalls past the watchdog limit
        bus(32'h0000_0010, 2'b10);
        tick();
        bus(32'hF000_0000, 2'b00);
        hreadyout_mux = 1'b0;
        low = 0;
        @(negedge hclk);
        while (hready === 1'b0 && hresp === 2'b00 && low < 40) begin
            low++;
            tick();
            @(negedge hclk);
        end
        chk("stall_low_cycles", 32'(low), 32'd16);
        chk("tmo1_hready", 32'(hready), 32'd0);
        chk("tmo1_hresp", 32'(hresp), 32'd1);
        chk("tmo1_mux", 32'(mux_sel), 32'd0);
        chk("tmo1_cnt", 32'(err_cnt), 32'd3);
        tick();
        @(negedge hclk);
        chk("tmo2_hready", 32'(hready), 32'd1);
        chk("tmo2_hresp", 32'(hresp), 32'd1);
        chk("tmo2_flag", 32'(timeout_flag), 32'd1);
        tick();
        hreadyout_mux = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge hclk);
        chk("flag_cleared", 32'(timeout_flag), 32'd0);

        // Second stall: err_clr during TMO1, unmapped accept during TMO2
        tick();
        bus(32'h2000_0000, 2'b10);
        tick();
        bus(32'h3000_0000, 2'b10);
        hreadyout_mux = 1'b0;
        low = 0;
        @(negedge hclk);
        while (hresp !== 2'b01 && low < 40) begin
            low++;
            tick();
            @(negedge hclk);
        end
        chk("stall2_low_cycles", 32'(low), 32'd16);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge hclk);
        chk("clr_in_tmo1_flag", 32'(timeout_flag), 32'd1);
        chk("clr_in_tmo1_cnt", 32'(err_cnt), 32'd0);
        tick();
        bus(32'hF000_0000, 2'b00);
        hreadyout_mux = 1'b1;
        @(negedge hclk);
        chk("tmo2_to_err1", {30'd0, hready, hresp[0]}, 32'd1);
        chk("tmo2_to_err1_cnt", 32'(err_cnt), 32'd1);
        tick();
        tick();

        // Reset asserted mid ERR1
        bus(32'h3000_0000, 2'b10);
        tick();
        bus(32'hF000_0000, 2'b00);
        #1 hresetn = 1'b0;
        #1;
        chk("rst_mid_hready", 32'(hready), 32'd1);
        chk("rst_mid_hresp", 32'(hresp), 32'd0);
        chk("rst_mid_cnt", 32'(err_cnt), 32'd0);
        chk("rst_mid_flag", 32'(timeout_flag), 32'd0);
        tick();
        hresetn = 1'b1;
        tick();

        // Counter saturation then clear
        bus(32'h3000_0000, 2'b10);
        repeat (600) tick();
        @(negedge hclk);
        chk("cnt_saturated", 32'(err_cnt), 32'd255);
        tick();
        bus(32'hF000_0000, 2'b00);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge hclk);
        chk("cnt_cleared", 32'(err_cnt), 32'd0);
        repeat (3) tick();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got stuck expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
